// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, register
// offsets inside the four-port window, and the default window base.
package interrupt_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } arb_state_e;

  localparam logic [1:0] OFS_STATUS = 2'd0;
  localparam logic [1:0] OFS_MASK   = 2'd1;
  localparam logic [1:0] OFS_PEND   = 2'd2;
  localparam logic [1:0] OFS_EOI    = 2'd3;

  localparam logic [15:0] DEFAULT_BASE_ID = 16'h0010;

endpackage

// File: rtl/interrupt_arbiter_prio_pick.sv
// Combinational winner selection: fixed priority (bit 0 first) or a rotating
// scan that starts at rr_ptr_i and wraps around.
module interrupt_arbiter_prio_pick #(
  parameter int N_SRC       = 4,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [3:0]       rr_ptr_i,
  output logic             hit_o,
  output logic [3:0]       idx_o
);

  logic [3:0]       shiftAmt;
  logic [N_SRC-1:0] rotReq;

  // Rotate the request vector so the scan start lands at bit 0; the winning
  // rotated position is then mapped back by adding the rotation modulo N_SRC.
  always_comb begin
    logic [4:0] sum;
    shiftAmt = ROUND_ROBIN ? rr_ptr_i : 4'd0;
    rotReq   = N_SRC'({req_i, req_i} >> shiftAmt);
    hit_o    = 1'b0;
    idx_o    = 4'd0;
    sum      = 5'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!hit_o && rotReq[i]) begin
        hit_o = 1'b1;
        sum   = 5'(i) + {1'b0, shiftAmt};
        idx_o = (sum >= 5'(N_SRC)) ? 4'(sum - 5'(N_SRC)) : sum[3:0];
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Shares the processor INTERRUPT line among N_SRC edge-triggered sources, with
// mask/pending/status/EOI registers in a four-port I/O window.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int          N_SRC       = 4,
  parameter logic [15:0] BASE_ID     = DEFAULT_BASE_ID,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [15:0]      PORT_ID,
  input  logic [15:0]      OUT_PORT,
  input  logic             WRITE_STROBE,
  input  logic             READ_STROBE,
  input  logic             INTERRUPT_ACK,
  output logic             INTERRUPT,
  output logic [15:0]      RD_DATA,
  output logic             RD_HIT
);

  arb_state_e       state_q, state_d;
  logic [N_SRC-1:0] irqPrev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [3:0]       activeId_q, activeId_d;
  logic             activeValid_q, activeValid_d;
  logic             intReq_q, intReq_d;
  logic [3:0]       rrPtr_q, rrPtr_d;

  logic [15:0]      portOfs;
  logic [1:0]       regSel;
  logic             wrMask, wrPend, wrEoi;
  logic             ackTake, eoiTake;
  logic [N_SRC-1:0] rise, req, ackClr, w1cClr;
  logic             pickHit;
  logic [3:0]       pickIdx;
  logic             unusedBits;

  assign unusedBits = ^{READ_STROBE, OUT_PORT};

  assign portOfs = PORT_ID - BASE_ID;
  assign regSel  = portOfs[1:0];
  assign RD_HIT  = (portOfs < 16'd4);
  assign wrMask  = WRITE_STROBE && RD_HIT && (regSel == OFS_MASK);
  assign wrPend  = WRITE_STROBE && RD_HIT && (regSel == OFS_PEND);
  assign wrEoi   = WRITE_STROBE && RD_HIT && (regSel == OFS_EOI);
  assign ackTake = (state_q == ASSERT) && INTERRUPT_ACK;
  assign eoiTake = (state_q == SERVICE) && wrEoi;

  assign rise = IRQ_IN & ~irqPrev_q;
  assign req  = pend_q & ~mask_q;

  interrupt_arbiter_prio_pick #(
    .N_SRC       (N_SRC),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_prio_pick (
    .req_i    (req),
    .rr_ptr_i (rrPtr_q),
    .hit_o    (pickHit),
    .idx_o    (pickIdx)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pickHit) state_d = ASSERT;
      ASSERT:  if (ackTake) state_d = SERVICE;
      SERVICE: if (eoiTake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge is OR-ed in after the ACK and W1C clears so it is never lost.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      ackClr[i] = ackTake && (activeId_q == 4'(i));
    end
    w1cClr        = wrPend ? OUT_PORT[N_SRC-1:0] : '0;
    pend_d        = (pend_q & ~ackClr & ~w1cClr) | rise;
    mask_d        = wrMask ? OUT_PORT[N_SRC-1:0] : mask_q;
    activeId_d    = activeId_q;
    activeValid_d = activeValid_q;
    intReq_d      = intReq_q;
    rrPtr_d       = rrPtr_q;
    unique case (state_q)
      IDLE: begin
        if (pickHit) begin
          activeId_d = pickIdx;
          intReq_d   = 1'b1;
        end
      end
      ASSERT: begin
        if (ackTake) begin
          intReq_d      = 1'b0;
          activeValid_d = 1'b1;
        end
      end
      SERVICE: begin
        if (eoiTake) begin
          activeValid_d = 1'b0;
          if (ROUND_ROBIN) begin
            rrPtr_d = (activeId_q == 4'(N_SRC - 1)) ? 4'd0 : activeId_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      irqPrev_q     <= '0;
      pend_q        <= '0;
      mask_q        <= '1;
      activeId_q    <= 4'd0;
      activeValid_q <= 1'b0;
      intReq_q      <= 1'b0;
      rrPtr_q       <= 4'd0;
    end else begin
      irqPrev_q     <= IRQ_IN;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      activeId_q    <= activeId_d;
      activeValid_q <= activeValid_d;
      intReq_q      <= intReq_d;
      rrPtr_q       <= rrPtr_d;
    end
  end

  assign INTERRUPT = intReq_q;

  always_comb begin
    RD_DATA = 16'h0000;
    if (RD_HIT) begin
      unique case (regSel)
        OFS_STATUS: RD_DATA = {activeValid_q, 11'b0, activeId_q};
        OFS_MASK:   RD_DATA = 16'(mask_q);
        OFS_PEND:   RD_DATA = 16'(pend_q);
        default:    RD_DATA = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
Shares the single INTERRUPT input of tramelblaze_top among N_SRC peripheral interrupt sources, such as the counter tick and the button debouncer.
- Latches rising edges into a pending register and applies a software mask.
- Drives INTERRUPT and holds it until INTERRUPT_ACK.
- Records which source won, then blocks further interrupts until the ISR writes end-of-interrupt (EOI).
- Exposes status, mask, pending and EOI as I/O ports decoded from PORT_ID/READ_STROBE/WRITE_STROBE.

Parameters:
N_SRC, 4, number of interrupt sources (1..16).
BASE_ID, 16'h0010, first of four consecutive port IDs owned by the block.
ROUND_ROBIN, 0, 0 = fixed priority (bit 0 highest); 1 = rotating priority starting after the last serviced source.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous reset, active-low (asserted when 0).
IRQ_IN  in  N_SRC  interrupt sources, synchronous to CLK, rising-edge sensitive.
PORT_ID  in  16  processor port address.
OUT_PORT  in  16  processor write data.
WRITE_STROBE  in  1  processor write qualifier, one cycle.
READ_STROBE  in  1  processor read qualifier, one cycle.
INTERRUPT_ACK  in  1  processor acknowledge.
INTERRUPT  out  1  interrupt request to the processor.
RD_DATA  out  16  read data, muxed by the top level onto IN_PORT.
RD_HIT  out  1  1 when PORT_ID is in BASE_ID..BASE_ID+3 (combinational); top-level IN_PORT mux select.

Behaviour:
- Reset (RESET==0 at a clock edge): PEND=0, MASK=all ones (all sources masked), ACTIVE_VALID=0, ACTIVE_ID=0, INTERRUPT=0, state=IDLE, irq_prev=0, rr_ptr=0. RD_DATA/RD_HIT follow the combinational decode. Reset mid-operation aborts any request or service with no residue.
- Edge detect: irq_prev<=IRQ_IN every cycle. PEND[i] sets at the edge where IRQ_IN[i]=1 and irq_prev[i]=0. A source held high sets PEND once only.
- Request: req = PEND & ~MASK.
- FSM states:
  - IDLE: if req!=0, capture winner into ACTIVE_ID, set INTERRUPT<=1, go to ASSERT. Latency: IRQ_IN rises before edge k, PEND set at edge k, INTERRUPT high after edge k+1.
  - ASSERT: INTERRUPT held at 1. On INTERRUPT_ACK=1: INTERRUPT<=0, ACTIVE_VALID<=1, PEND[ACTIVE_ID]<=0, go to SERVICE. The winner does not change while in ASSERT.
  - SERVICE: INTERRUPT=0 and no new request is issued. An EOI write clears ACTIVE_VALID and returns to IDLE. In ROUND_ROBIN=1, rr_ptr<=ACTIVE_ID+1 modulo N_SRC at EOI.
- Priority:
  - ROUND_ROBIN=0: lowest set index of req wins.
  - ROUND_ROBIN=1: first set bit of req scanning from rr_ptr upward, wrapping around.
- Port map (offsets from BASE_ID):
  - +0 read STATUS = {ACTIVE_VALID, 7'b0, 4'b0, ACTIVE_ID[3:0]}. Writes ignored.
  - +1 read/write MASK (zero-extended; write uses OUT_PORT[N_SRC-1:0]).
  - +2 read PEND. Write is W1C: PEND &= ~OUT_PORT[N_SRC-1:0].
  - +3 write EOI (data ignored). Reads 16'h0000.
- Decode: RD_DATA is valid combinationally whenever RD_HIT=1. READ_STROBE has no side effects.
- Simultaneous events:
  - New edge on bit i in the same cycle as its ACK clear or W1C: set wins, PEND[i]=1.
  - MASK write during ASSERT does not withdraw the request.
  - EOI outside SERVICE: ignored.
  - INTERRUPT_ACK outside ASSERT: ignored.
- Widths: sources at or above N_SRC read as 0. ACTIVE_ID is 4 bits.

Decomposition:
- Shared package tb_io_pkg:
  - FSM state encoding: IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2.
  - Register offsets: OFS_STATUS=0, OFS_MASK=1, OFS_PEND=2, OFS_EOI=3.
  - Default BASE_ID.
- One natural sub-module, prio_pick: combinational priority encoder (req, rr_ptr, ROUND_ROBIN) -> {hit, idx[3:0]}.

Test Plan:
- Reset and mask: RESET=0 for 10 cycles, release, pulse IRQ_IN=4'b0001 -> INTERRUPT stays 0, read +2 returns 16'h0001, read +1 returns 16'h000F.
- Basic service: write MASK=16'h0000, pulse IRQ_IN[2] before edge k -> INTERRUPT=1 after edge k+1. Assert INTERRUPT_ACK -> INTERRUPT=0, +0 reads 16'h8002, +2 reads 0. Write +3 -> +0 reads 16'h0002.
- Fixed priority: ROUND_ROBIN=0, IRQ_IN=4'b1010 rising together -> first ACTIVE_ID=1. After EOI, second INTERRUPT yields ACTIVE_ID=3.
- Round robin: ROUND_ROBIN=1, sources 0 and 1 re-pulsed after every EOI -> ACTIVE_ID sequence 0,1,0,1.
- Collisions: edge on IRQ_IN[0] in the same cycle as its ACK -> PEND[0] stays 1, and a second INTERRUPT follows EOI. Edge on IRQ_IN[3] in the same cycle as a W1C of 16'h0008 -> PEND[3]=1.
- Mid-op reset and stray events: RESET=0 while in ASSERT -> INTERRUPT=0 next edge, all registers at reset values. Stray INTERRUPT_ACK or EOI in IDLE -> no state change.
